fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side adapter that sits directly downstream of the synchronous-read FIFO.
//  Drives the FIFO's rd_en, absorbs its 1-cycle dout latency into a small skid buffer,
//  and presents a valid/ready stream to the memory-controller request logic.
//  Sustains 1 word/cycle with no combinational path from out_ready to fifo_rd_en.
// PARAMETERS
//  WIDTH      8   data width; equals the upstream FIFO WIDTH
//  BUF_DEPTH  3   skid entries; values below 3 are illegal (elaboration error)
//  CNT_WIDTH  $clog2(BUF_DEPTH+1)  width of the occupancy counters
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  fifo_empty  in   1      upstream FIFO empty flag
//  fifo_rd_en  out  1      read strobe to FIFO; word appears on fifo_dout next cycle
//  fifo_dout   in   WIDTH  upstream FIFO read data, valid the cycle after fifo_rd_en
//  out_valid   out  1      out_data holds a word
//  out_ready   in   1      consumer accepts; transfer when out_valid & out_ready
//  out_data    out  WIDTH  head-of-buffer word
// BEHAVIOUR
//  - State: buffer array, head/tail ptrs (mod BUF_DEPTH), count (0..BUF_DEPTH),
//    inflight (1 bit, set when fifo_rd_en was high last cycle).
//  - fifo_rd_en = ~rst & ~fifo_empty & (count + inflight < BUF_DEPTH). Depends only on
//    registered state and fifo_empty, never on out_ready.
//  - When inflight=1: fifo_dout is written at tail; tail advances.
//  - pop = out_valid & out_ready: head advances.
//  - count_next = count + inflight - pop. Push and pop in the same cycle leave count unchanged.
//  - out_valid = (count != 0). out_data = buf[head]. There is no bypass path.
//  - Latency: fifo_rd_en at cycle t -> word in buffer at t+1 -> out_valid at t+2 (if buffer was empty).
//  - Throughput: with out_ready held high and the FIFO non-empty, one transfer per cycle
//    after the initial 2-cycle fill.
//  - Full: count + inflight == BUF_DEPTH -> fifo_rd_en = 0. Overflow is impossible by construction.
//  - Empty: count == 0 -> out_valid = 0. out_data is don't-care.
//  - Pointer wrap: BUF_DEPTH-1 -> 0. BUF_DEPTH is not required to be a power of 2.
//  - Ordering: words leave in exactly the order they were read from the FIFO.
//  - out_valid stays high until accepted. out_data stays stable while out_valid & ~out_ready.
//  - Reset (any cycle, including mid-transfer): count=0, inflight=0, head=tail=0,
//    out_valid=0, fifo_rd_en=0. A word in flight during rst is discarded.
//    The upstream FIFO is reset on the same rst, so no data is lost relative to it.
//  - Buffer contents are not reset.
// STRUCTURE
//  - Counters and pointers use the REGISTER_R_CE primitive (ce/rst, INIT=0), as the FIFO does.
//  - The data array is plain registers with no reset.
//  - No package content is needed. Optionally move the BUF_DEPTH>=3 check and CNT_WIDTH
//    into the shared memory-controller header alongside the FIFO constants.
//  - One natural sub-module: skid_ring_buffer (array + head/tail/count),
//    reusable by other read-side adapters.
// TESTING (bench pairs this block with the real fifo, WIDTH=8, DEPTH=32)
//  - Reset: hold rst 3 cycles with the FIFO non-empty -> fifo_rd_en=0, out_valid=0 throughout;
//    first fifo_rd_en in the first cycle after rst falls.
//  - Single word: write 0xA5 into the empty FIFO, out_ready=1 -> fifo_rd_en one cycle,
//    out_valid 2 cycles later with out_data=0xA5, then out_valid=0.
//  - Streaming: preload 0x00..0x1F, out_ready=1 -> 32 transfers on 32 consecutive cycles,
//    in order, starting 2 cycles after the first rd_en.
//  - Backpressure: preload 10 words, out_ready=0 -> exactly 3 reads issued, count=3,
//    out_data=word0 held stable; release -> remaining words in order, no gaps beyond the refill.
//  - Random ready: random out_ready (50%) plus random FIFO writes, 2000 words -> scoreboard
//    matches in order; no rd_en while fifo_empty; count never exceeds 3.
//  - Mid-stream reset: assert rst while count=2 and inflight=1 -> out_valid=0 the next cycle;
//    a fresh write after reset is delivered correctly with no stale words.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO read-side adapters.
// Holds the minimum skid depth and the occupancy-counter sizing helper.
package fifo_stream_reader_pkg;

  // Two slots cover the 1-cycle read latency; the third keeps
  // full throughput without a ready -> rd_en combinational path.
  localparam int unsigned MIN_BUF_DEPTH = 3;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skid_ring_buffer.sv
// Small ring buffer with head/tail/count, no bypass path.
// Reusable skid storage for read-side adapters.
module skid_ring_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [CNT_WIDTH-1:0] count,
  output logic [WIDTH-1:0]     head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     head_next;
  logic [PTR_W-1:0]     tail_next;
  logic [CNT_WIDTH-1:0] count_next;

  // Explicit wrap so DEPTH need not be a power of two.
  always_comb begin
    head_next = (head == LAST) ? '0 : head + 1'b1;
    tail_next = (tail == LAST) ? '0 : tail + 1'b1;
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (pop) begin
      head <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail <= '0;
    end else if (push) begin
      tail <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push ^ pop) begin
      count <= count_next;
    end
  end

  // Data array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a synchronous-read FIFO: issues rd_en,
// absorbs the 1-cycle dout latency and offers a valid/ready stream.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3,
  parameter int unsigned CNT_WIDTH = cnt_width(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (BUF_DEPTH < MIN_BUF_DEPTH) begin : g_depth_check
    $error("BUF_DEPTH must be at least %0d", MIN_BUF_DEPTH);
  end

  logic                 inflight;
  logic                 pop;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH:0]   occupancy;

  // Reserve a slot for the word already requested, so the
  // read strobe never depends on out_ready.
  assign occupancy = {1'b0, count}
                   + {{CNT_WIDTH{1'b0}}, inflight};

  assign fifo_rd_en = ~rst & ~fifo_empty
                    & (occupancy < (CNT_WIDTH + 1)'(BUF_DEPTH));

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  skid_ring_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (BUF_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .count     (count),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural sync-read FIFO
// and a word-count reference model plus in-order scoreboard.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_rst = 1'b1;
  logic       out_ready = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       out_valid;
  logic [7:0] out_data;

  fifo_stream_reader #(
    .WIDTH     (8),
    .BUF_DEPTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO: depth 32, dout valid the cycle after rd_en.
  logic [7:0] mem [32];
  int         wp = 0;
  int         rp = 0;
  logic [7:0] sb [$];

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= 0;
      rp <= 0;
      sb.delete();
    end else begin
      if (fifo_rd_en) begin
        fifo_dout <= mem[rp % 32];
        rp <= rp + 1;
      end
      if (wr_en) begin
        mem[wp % 32] <= wr_data;
        wp <= wp + 1;
        sb.push_back(wr_data);
      end
    end
  end

  // Reference: words buffered (held) and word requested last cycle (pend).
  int         held = 0;
  int         pend = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         xf_cnt = 0;
  int         first_rd = -1;
  int         first_xf = -1;
  int         last_xf = -1;
  logic [7:0] last_data = 8'h00;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    logic exp_rd;
    logic exp_vld;
    int   mxfer;
    cyc++;
    exp_vld = (held > 0);
    exp_rd = !rst && !fifo_empty && (held + pend < 3);
    chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (hold_pend && !rst) begin
      chk("hold", 32'(out_data), 32'(hold_data));
    end
    hold_pend = out_valid && !out_ready && !rst;
    hold_data = out_data;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        chk("extra_word", 32'(sb.size()), 32'd1);
      end else begin
        chk("data", 32'(out_data), 32'(sb.pop_front()));
      end
      xf_cnt++;
      if (first_xf < 0) first_xf = cyc;
      last_xf = cyc;
      last_data = out_data;
    end
    if (fifo_rd_en && !rst) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    mxfer = (exp_vld && out_ready) ? 1 : 0;
    if (rst) begin
      held = 0;
      pend = 0;
    end else begin
      held = held + pend - mxfer;
      pend = exp_rd ? 1 : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    rd_cnt = 0;
    xf_cnt = 0;
    first_rd = -1;
    first_xf = -1;
    last_xf = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    wr_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (sb.size() == 0 && held == 0 && pend == 0) break;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int nw;
    int found;

    // Reset with FIFO filling while adapter held in reset.
    out_ready = 1'b1;
    step();
    fifo_rst = 1'b0;
    for (int i = 0; i < 4; i++) put(8'h10 + 8'(i));
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_rd", 32'(fifo_rd_en), 32'd1);
    step();
    drain();

    // Single word latency.
    clr();
    put(8'hA5);
    repeat (6) step();
    chk("single_rd", 32'(rd_cnt), 32'd1);
    chk("single_xf", 32'(xf_cnt), 32'd1);
    chk("single_lat", 32'(first_xf - first_rd), 32'd2);
    chk("single_data", 32'(last_data), 32'hA5);

    // Streaming 32 words.
    clr();
    for (int i = 0; i < 32; i++) put(8'(i));
    drain();
    chk("stream_xf", 32'(xf_cnt), 32'd32);
    chk("stream_span", 32'(last_xf - first_xf + 1), 32'd32);
    chk("stream_lat", 32'(first_xf - first_rd), 32'd2);
    chk("stream_last", 32'(last_data), 32'h1F);

    // Backpressure: 10 words, consumer stalled.
    clr();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) put(8'h40 + 8'(i));
    repeat (5) step();
    chk("bp_reads", 32'(rd_cnt), 32'd3);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'h40);
    clr();
    drain();
    chk("bp_xf", 32'(xf_cnt), 32'd10);
    chk("bp_span", 32'(last_xf - first_xf + 1), 32'd10);
    chk("bp_last", 32'(last_data), 32'h49);

    // Random ready and random writes.
    nw = 0;
    for (int c = 0; c < 20000 && nw < 2000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && (wp - rp) < 32) begin
        put(8'($urandom));
        nw++;
      end else begin
        step();
      end
    end
    drain();

    // Mid-stream reset with two buffered and one in flight.
    out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (held == 2 && pend == 1) found = 1;
      else if (i < 5) put(8'h70 + 8'(i));
      else step();
    end
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    fifo_rst = 1'b1;
    step();
    rst = 1'b0;
    fifo_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    step();
    clr();
    put(8'h3C);
    drain();
    chk("mid_xf", 32'(xf_cnt), 32'd1);
    chk("mid_data", 32'(last_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
